// File: rtl/r4_input_gather.sv
// Ping-pong reorder buffer ahead of the first radix-4 stage. It collects a frame of N serial
// samples, then presents groups of four stride-N/4 samples while the other bank fills.
module r4_input_gather #(
    parameter int unsigned N  = 16,
    parameter int unsigned GW = ((N / 4) > 1) ? $clog2(N / 4) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [31:0]   X0r,
    output logic [31:0]   X1r,
    output logic [31:0]   X2r,
    output logic [31:0]   X3r,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [GW-1:0] out_group,
    output logic          out_last
);

    localparam int unsigned DW = 32;
    localparam int unsigned Q  = N / 4;
    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

    logic [DW-1:0] mem_q [2][N];

    logic          wr_bank_q, wr_bank_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic          rd_bank_q, rd_bank_d;
    logic [GW-1:0] rd_group_q, rd_group_d;
    logic [1:0]    full_q, full_d;

    logic          wr_en;
    logic          xfer;
    logic          wr_last;
    logic          rd_last;
    logic [PW-1:0] rd_addr [4];

    // Pointer and flag next-state; a release and a fill always target different banks.
    always_comb begin
        wr_bank_d  = wr_bank_q;
        wr_ptr_d   = wr_ptr_q;
        rd_bank_d  = rd_bank_q;
        rd_group_d = rd_group_q;
        full_d     = full_q;

        wr_en   = in_valid & ~full_q[wr_bank_q];
        xfer    = full_q[rd_bank_q] & out_ready;
        wr_last = (wr_ptr_q == PW'(N - 1));
        rd_last = (rd_group_q == GW'(Q - 1));

        if (xfer) begin
            if (rd_last) begin
                full_d[rd_bank_q] = 1'b0;
                rd_group_d        = '0;
                rd_bank_d         = ~rd_bank_q;
            end else begin
                rd_group_d = rd_group_q + GW'(1);
            end
        end

        if (wr_en) begin
            if (wr_last) begin
                full_d[wr_bank_q] = 1'b1;
                wr_ptr_d          = '0;
                wr_bank_d         = ~wr_bank_q;
            end else begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_bank_q  <= 1'b0;
            wr_ptr_q   <= '0;
            rd_bank_q  <= 1'b0;
            rd_group_q <= '0;
            full_q     <= '0;
        end else begin
            wr_bank_q  <= wr_bank_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_bank_q  <= rd_bank_d;
            rd_group_q <= rd_group_d;
            full_q     <= full_d;
        end
    end

    // Sample storage carries no reset; stale contents are never presented.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_bank_q][wr_ptr_q] <= in_data;
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < 4; k++) begin
            rd_addr[k] = PW'(rd_group_q) + PW'(k * Q);
        end
    end

    assign in_ready  = ~full_q[wr_bank_q];
    assign out_valid = full_q[rd_bank_q];
    assign out_group = rd_group_q;
    assign out_last  = rd_last & full_q[rd_bank_q];

    assign X0r = mem_q[rd_bank_q][rd_addr[0]];
    assign X1r = mem_q[rd_bank_q][rd_addr[1]];
    assign X2r = mem_q[rd_bank_q][rd_addr[2]];
    assign X3r = mem_q[rd_bank_q][rd_addr[3]];

endmodule

// File: tb/tb_r4_input_gather.sv
// Directed bench for r4_input_gather (N=16): ordering, latency, backpressure, stalls,
// mid-frame reset and coincident fill/release.
module tb_r4_input_gather;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] X0r, X1r, X2r, X3r;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_group;
    logic        out_last;

    int total = 0;
    int bad   = 0;

    logic        acc, xf, clast;
    logic [31:0] cx [4];
    logic [1:0]  cgrp;
    logic [31:0] fl [16];
    logic [31:0] frm [16];

    r4_input_gather #(.N(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .X0r       (X0r),
        .X1r       (X1r),
        .X2r       (X2r),
        .X3r       (X3r),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_group (out_group),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Entered at a negedge: drive inputs, record the handshakes at the coming posedge.
    task automatic tick(input logic iv, input logic [31:0] d, input logic ordy);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        #1;
        acc   = iv & in_ready;
        xf    = out_valid & ordy;
        cx[0] = X0r;
        cx[1] = X1r;
        cx[2] = X2r;
        cx[3] = X3r;
        cgrp  = out_group;
        clast = out_last;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic fill_frm(input logic [31:0] base);
        for (int i = 0; i < 16; i++) frm[i] = base + 32'(i);
    endtask

    // Drains four groups with out_ready=1 and checks them against the expected frame.
    task automatic drain_frame(input string tag, input logic [31:0] ef [16]);
        for (int g = 0; g < 4; g++) begin
            tick(1'b0, 32'h0, 1'b1);
            chk({tag, "_xfer"}, 32'(xf), 32'd1);
            chk({tag, "_grp"}, 32'(cgrp), 32'(g));
            chk({tag, "_last"}, 32'(clast), (g == 3) ? 32'd1 : 32'd0);
            for (int k = 0; k < 4; k++) chk({tag, "_x"}, cx[k], ef[g + 4 * k]);
        end
    endtask

    initial begin
        int n, eg;
        logic [3:0] pat [16];
        fl = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
               32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
               32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
               32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};
        pat = '{4'd1, 4'd0, 4'd0, 4'd1, 4'd0, 4'd1, 4'd1, 4'd0,
                4'd0, 4'd0, 4'd1, 4'd0, 4'd1, 4'd0, 4'd0, 4'd1};

        // Reset state
        do_reset();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_out_group", 32'(out_group), 32'd0);

        // Basic order and latency with 1.0..16.0
        n = 0;
        for (int i = 0; i < 16; i++) begin
            tick(1'b1, fl[i], 1'b1);
            if (acc) n++;
            if (i < 15) chk("lat_early_valid", 32'(out_valid), 32'd0);
        end
        chk("basic_accepts", 32'(n), 32'd16);
        chk("lat_valid", 32'(out_valid), 32'd1);
        chk("lat_group", 32'(out_group), 32'd0);
        chk("g0_x0", X0r, 32'h3F800000);
        chk("g0_x1", X1r, 32'h40A00000);
        chk("g0_x2", X2r, 32'h41100000);
        chk("g0_x3", X3r, 32'h41500000);
        drain_frame("basic", fl);
        chk("g3_x0", cx[0], 32'h40800000);
        chk("g3_x3", cx[3], 32'h41800000);
        chk("basic_done_valid", 32'(out_valid), 32'd0);

        // Backpressure: two frames accepted, then stall until a release
        do_reset();
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick(1'b1, 32'h1000 + 32'(n), 1'b0);
            if (acc) n++;
        end
        chk("bp_accepts", 32'(n), 32'd32);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        fill_frm(32'h1000);
        drain_frame("bp_f1", frm);
        chk("bp_ready_back", 32'(in_ready), 32'd1);
        fill_frm(32'h1010);
        drain_frame("bp_f2", frm);
        chk("bp_done_valid", 32'(out_valid), 32'd0);

        // Stall stability
        do_reset();
        fill_frm(32'h2000);
        for (int i = 0; i < 16; i++) tick(1'b1, frm[i], 1'b0);
        eg = 0;
        for (int c = 0; c < 40 && eg < 4; c++) begin
            chk("st_valid", 32'(out_valid), 32'd1);
            chk("st_grp", 32'(out_group), 32'(eg));
            chk("st_x0", X0r, frm[eg]);
            chk("st_x1", X1r, frm[eg + 4]);
            chk("st_x2", X2r, frm[eg + 8]);
            chk("st_x3", X3r, frm[eg + 12]);
            tick(1'b0, 32'h0, pat[c % 16][0]);
            if (xf) eg++;
        end
        chk("st_groups", 32'(eg), 32'd4);
        chk("st_done_valid", 32'(out_valid), 32'd0);

        // Reset mid-frame discards the partial frame
        do_reset();
        for (int i = 0; i < 7; i++) tick(1'b1, 32'hDEAD0000 + 32'(i), 1'b1);
        do_reset();
        chk("mr_in_ready", 32'(in_ready), 32'd1);
        chk("mr_valid0", 32'(out_valid), 32'd0);
        fill_frm(32'h3000);
        for (int i = 0; i < 16; i++) begin
            tick(1'b1, frm[i], 1'b1);
            if (i < 15) chk("mr_early_valid", 32'(out_valid), 32'd0);
        end
        chk("mr_valid", 32'(out_valid), 32'd1);
        drain_frame("mr", frm);

        // Bank 0 last transfer coincides with bank 1 last write
        do_reset();
        for (int i = 0; i < 32; i++) tick(1'b1, 32'h4000 + 32'(i), (i >= 28) ? 1'b1 : 1'b0);
        chk("sim_last_acc", 32'(acc), 32'd1);
        chk("sim_last_xf", 32'(xf), 32'd1);
        chk("sim_last_grp", 32'(cgrp), 32'd3);
        chk("sim_valid", 32'(out_valid), 32'd1);
        chk("sim_group", 32'(out_group), 32'd0);
        chk("sim_in_ready", 32'(in_ready), 32'd1);
        fill_frm(32'h4010);
        drain_frame("sim", frm);
        chk("sim_done_valid", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
